// File: rtl/scanner_receiver_pkg.sv
// rtl/scanner_receiver_pkg.sv - state encodings and command codes shared with the scanner transmitter
package scanner_receiver_pkg;

  typedef enum logic [1:0] {
    CMD  = 2'b01,
    DATA = 2'b10
  } state_e;

  localparam logic [7:0] CMD_READY = 8'd2;
  localparam logic [7:0] CMD_START = 8'd3;
  localparam logic [7:0] CMD_FULL  = 8'd4;
  localparam logic [7:0] CMD_DATA  = 8'd7;

  localparam int TIMEOUT_DEFAULT = 16;

endpackage

// File: rtl/scanner_receiver_serial_shifter.sv
// rtl/scanner_receiver_serial_shifter.sv - LSB-first 8-bit deserializer with bit counter and frame-done strobe
module serial_shifter (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_ser_clk,
  input  logic       i_ser_data,
  input  logic       i_clear,
  output logic [2:0] o_bit_cnt,
  output logic [7:0] o_frame_byte,
  output logic       o_frame_done
);

  logic [7:0] r_shift;
  logic [2:0] r_bit_cnt;

  // Capture each strobed bit at its position; a clear (timeout) drops any partial frame.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_shift   <= 8'h00;
      r_bit_cnt <= 3'd0;
    end else if (i_clear) begin
      r_shift   <= 8'h00;
      r_bit_cnt <= 3'd0;
    end else if (i_ser_clk) begin
      r_shift[r_bit_cnt] <= i_ser_data;
      r_bit_cnt          <= r_bit_cnt + 3'd1;
    end
  end

  // The completed byte includes the bit arriving this cycle so the top can decode it immediately.
  assign o_bit_cnt    = r_bit_cnt;
  assign o_frame_done = i_ser_clk && (r_bit_cnt == 3'd7);
  assign o_frame_byte = {i_ser_data, r_shift[6:0]};

endmodule

// File: rtl/scanner_receiver.sv
// rtl/scanner_receiver.sv - scanner serial receiver: command decode, data holding register, idle-gap timeout
module scanner_receiver
  import scanner_receiver_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       serClk,
  input  logic       serData,
  input  logic       rxAck,
  output logic       cmdReady,
  output logic       cmdStart,
  output logic       cmdFull,
  output logic       frameErr,
  output logic [7:0] rxData,
  output logic       rxValid,
  output logic       rxOverflow,
  output logic       readyForTransferOut,
  output logic [1:0] ps
);

  localparam int GW = $clog2(TIMEOUT + 1);

  state_e        r_state;
  state_e        w_state_nxt;
  logic [2:0]    w_bit_cnt;
  logic [7:0]    w_frame_byte;
  logic          w_frame_done;
  logic [GW-1:0] r_gap;
  logic          w_gap_active;
  logic          w_timeout;
  logic          w_load;
  logic          w_ready_nxt, w_start_nxt, w_full_nxt, w_err_nxt;
  logic          r_cmd_ready, r_cmd_start, r_cmd_full, r_frame_err;
  logic [7:0]    r_rx_data;
  logic          r_rx_valid;
  logic          r_rx_overflow;

  serial_shifter u_shifter (
    .i_clk        (clk),
    .i_rst_n      (rst),
    .i_ser_clk    (serClk),
    .i_ser_data   (serData),
    .i_clear      (w_timeout),
    .o_bit_cnt    (w_bit_cnt),
    .o_frame_byte (w_frame_byte),
    .o_frame_done (w_frame_done)
  );

  // The gap only matters while a frame is partially received or a data byte is owed.
  assign w_gap_active = (w_bit_cnt != 3'd0) || (r_state == DATA);
  assign w_timeout    = !serClk && w_gap_active && (r_gap == GW'(TIMEOUT - 1));

  // Count consecutive idle strobes; restart after a timeout so it never saturates.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_gap <= '0;
    end else if (serClk || !w_gap_active || w_timeout) begin
      r_gap <= '0;
    end else begin
      r_gap <= r_gap + 1'b1;
    end
  end

  // State register; pulses are registered here so they appear one clock after bit 7.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= CMD;
      r_cmd_ready <= 1'b0;
      r_cmd_start <= 1'b0;
      r_cmd_full  <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cmd_ready <= w_ready_nxt;
      r_cmd_start <= w_start_nxt;
      r_cmd_full  <= w_full_nxt;
      r_frame_err <= w_err_nxt;
    end
  end

  // Next state and pulse decode; timeout wins over any frame decode.
  always_comb begin
    w_state_nxt = r_state;
    w_ready_nxt = 1'b0;
    w_start_nxt = 1'b0;
    w_full_nxt  = 1'b0;
    w_err_nxt   = 1'b0;
    w_load      = 1'b0;
    if (w_timeout) begin
      w_err_nxt   = 1'b1;
      w_state_nxt = CMD;
    end else begin
      case (r_state)
        CMD: begin
          if (w_frame_done) begin
            case (w_frame_byte)
              CMD_READY: w_ready_nxt = 1'b1;
              CMD_START: w_start_nxt = 1'b1;
              CMD_FULL:  w_full_nxt  = 1'b1;
              CMD_DATA:  w_state_nxt = DATA;
              default:   w_err_nxt   = 1'b1;
            endcase
          end
        end
        DATA: begin
          if (w_frame_done) begin
            w_load      = 1'b1;
            w_state_nxt = CMD;
          end
        end
        default: w_state_nxt = CMD;
      endcase
    end
  end

  // Holding register: a new byte always loads; overflow only if the old byte was never acknowledged.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rx_data     <= 8'h00;
      r_rx_valid    <= 1'b0;
      r_rx_overflow <= 1'b0;
    end else if (w_load) begin
      r_rx_data  <= w_frame_byte;
      r_rx_valid <= 1'b1;
      if (r_rx_valid && !rxAck) begin
        r_rx_overflow <= 1'b1;
      end
    end else if (rxAck && r_rx_valid) begin
      r_rx_valid <= 1'b0;
    end
  end

  assign cmdReady            = r_cmd_ready;
  assign cmdStart            = r_cmd_start;
  assign cmdFull             = r_cmd_full;
  assign frameErr            = r_frame_err;
  assign rxData              = r_rx_data;
  assign rxValid             = r_rx_valid;
  assign rxOverflow          = r_rx_overflow;
  assign readyForTransferOut = !r_rx_valid && (r_state == CMD);
  assign ps                  = r_state;

endmodule

// File: tb/tb_scanner_receiver.sv
// tb/tb_scanner_receiver.sv - scoreboard bench for scanner_receiver
module tb_scanner_receiver;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       serClk = 1'b0;
  logic       serData = 1'b0;
  logic       rxAck = 1'b0;
  logic       cmdReady, cmdStart, cmdFull, frameErr;
  logic [7:0] rxData;
  logic       rxValid, rxOverflow, readyForTransferOut;
  logic [1:0] ps;

  scanner_receiver #(.TIMEOUT(16)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .serClk              (serClk),
    .serData             (serData),
    .rxAck               (rxAck),
    .cmdReady            (cmdReady),
    .cmdStart            (cmdStart),
    .cmdFull             (cmdFull),
    .frameErr            (frameErr),
    .rxData              (rxData),
    .rxValid             (rxValid),
    .rxOverflow          (rxOverflow),
    .readyForTransferOut (readyForTransferOut),
    .ps                  (ps)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Pulse codes: 1 ready, 2 start, 3 full, 4 frame error.
  typedef struct {
    int code;
    int cyc;
  } exp_t;

  exp_t sbq[$];
  int   n_vec  = 0;
  int   n_fail = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_exp(input int code, input int at_cyc);
    exp_t e;
    e.code = code;
    e.cyc  = at_cyc;
    sbq.push_back(e);
  endtask

  task automatic send_bits(input logic [7:0] b, input int n, input int code, input logic ack7);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      serClk  = 1'b1;
      serData = b[i];
      rxAck   = (i == 7) ? ack7 : 1'b0;
      if (i == 7 && code != 0) push_exp(code, cyc + 1);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      serClk  = 1'b0;
      serData = 1'b0;
      rxAck   = 1'b0;
    end
  endtask

  // Monitor: any pulse pops the scoreboard and is checked for kind and cycle.
  always @(negedge clk) begin
    int   code;
    int   npulse;
    exp_t e;
    if (rst) begin
      npulse = int'(cmdReady) + int'(cmdStart) + int'(cmdFull) + int'(frameErr);
      code   = cmdReady ? 1 : cmdStart ? 2 : cmdFull ? 3 : frameErr ? 4 : 0;
      if (npulse != 0) begin
        chk("pulse_onehot", npulse, 1);
        if (sbq.size() == 0) begin
          n_vec++;
          n_fail++;
          $display("FAIL unexpected_pulse: got code %0d at cycle %0d expected none", code, cyc);
        end else begin
          e = sbq.pop_front();
          chk("pulse_code", code, e.code);
          chk("pulse_cycle", cyc, e.cyc);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    idle(2);
    chk("rst_ps", ps, 1);
    chk("rst_rxValid", rxValid, 0);
    chk("rst_rxData", rxData, 0);
    chk("rst_overflow", rxOverflow, 0);
    chk("rst_rfto", readyForTransferOut, 1);
    chk("rst_pulses", cmdReady + cmdStart + cmdFull + frameErr, 0);
    @(posedge clk); #1; rst = 1'b1;
    idle(2);

    // Back-to-back commands.
    send_bits(8'h02, 8, 1, 1'b0);
    send_bits(8'h03, 8, 2, 1'b0);
    send_bits(8'h04, 8, 3, 1'b0);
    idle(3);
    chk("cmds_ps", ps, 1);

    // Data frame and acknowledge.
    send_bits(8'h07, 8, 0, 1'b0);
    idle(1);
    chk("data_ps_data", ps, 2);
    chk("data_rfto_in_data", readyForTransferOut, 0);
    send_bits(8'h05, 8, 0, 1'b0);
    idle(1);
    chk("data_ps_cmd", ps, 1);
    chk("data_rxData", rxData, 8'h05);
    chk("data_rxValid", rxValid, 1);
    chk("data_rfto_held", readyForTransferOut, 0);
    idle(2);
    chk("data_rxValid_hold", rxValid, 1);
    @(posedge clk); #1; rxAck = 1'b1;
    idle(1);
    chk("ack_rxValid", rxValid, 0);
    chk("ack_rfto", readyForTransferOut, 1);

    // Unknown command.
    send_bits(8'h09, 8, 4, 1'b0);
    idle(2);
    chk("badcmd_ps", ps, 1);

    // Partial frame timeout, then a clean frame.
    send_bits(8'h05, 3, 0, 1'b0);
    @(posedge clk); #1; serClk = 1'b0; serData = 1'b0;
    push_exp(4, cyc + 16);
    idle(20);
    chk("timeout_ps", ps, 1);
    send_bits(8'h02, 8, 1, 1'b0);
    idle(2);

    // Overflow without acknowledge.
    send_bits(8'h07, 8, 0, 1'b0);
    send_bits(8'h0A, 8, 0, 1'b0);
    send_bits(8'h07, 8, 0, 1'b0);
    send_bits(8'h0B, 8, 0, 1'b0);
    idle(2);
    chk("ovf_rxData", rxData, 8'h0B);
    chk("ovf_rxValid", rxValid, 1);
    chk("ovf_flag", rxOverflow, 1);
    @(posedge clk); #1; rst = 1'b0;
    #2;
    chk("ovf_cleared_by_rst", rxOverflow, 0);
    @(posedge clk); #1; rst = 1'b1;

    // Acknowledge coincident with second completion.
    send_bits(8'h07, 8, 0, 1'b0);
    send_bits(8'h0A, 8, 0, 1'b0);
    send_bits(8'h07, 8, 0, 1'b0);
    send_bits(8'h0B, 8, 0, 1'b1);
    idle(2);
    chk("coack_rxData", rxData, 8'h0B);
    chk("coack_rxValid", rxValid, 1);
    chk("coack_overflow", rxOverflow, 0);

    // Asynchronous reset mid-frame.
    send_bits(8'hFF, 4, 0, 1'b0);
    #3;
    rst = 1'b0;
    #1;
    chk("async_ps", ps, 1);
    chk("async_rxValid", rxValid, 0);
    chk("async_rxData", rxData, 0);
    chk("async_overflow", rxOverflow, 0);
    chk("async_rfto", readyForTransferOut, 1);
    chk("async_pulses", cmdReady + cmdStart + cmdFull + frameErr, 0);
    serClk = 1'b0;
    @(posedge clk); #1; rst = 1'b1;
    send_bits(8'h04, 8, 3, 1'b0);
    idle(3);

    chk("sb_empty", sbq.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/scanner_receiver.md
SCANNER_RECEIVER -- requirements
Module: scanner_receiver

Interface
REQ-001 Parameter: TIMEOUT, 16, idle-gap limit in clk cycles before a partial frame is discarded.
REQ-002 clk  input  1  system clock; all state changes on its rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-low.
REQ-004 serClk  input  1  serial bit strobe from the transmitting scanner; serData is valid in any clk cycle where serClk=1.
REQ-005 serData  input  1  serial data, 8-bit frames, LSB first.
REQ-006 rxAck  input  1  consumer acknowledge for the data holding register.
REQ-007 cmdReady  output  1  one-cycle pulse, command 2 (ready to transfer) received.
REQ-008 cmdStart  output  1  one-cycle pulse, command 3 (start scanning) received.
REQ-009 cmdFull  output  1  one-cycle pulse, command 4 (buffer full) received.
REQ-010 frameErr  output  1  one-cycle pulse, unknown command or timeout.
REQ-011 rxData  output  8  held data byte.
REQ-012 rxValid  output  1  rxData holds an unacknowledged byte.
REQ-013 rxOverflow  output  1  sticky, a byte was overwritten before acknowledge.
REQ-014 readyForTransferOut  output  1  high when rxValid=0 and state is CMD; drives the scanner's readyForTransferIn.
REQ-015 ps  output  2  current state, debug.

Function
REQ-016 States: CMD=2'b01 (receiving command frame), DATA=2'b10 (receiving data frame after command 7); 2'b00/2'b11 unused, recover to CMD next cycle.
REQ-017 Each cycle with serClk=1: shift serData into bit position bitCnt of an 8-bit shift register, bitCnt increments (3-bit, wraps 7->0).
REQ-018 Frame completes on the serClk=1 cycle with bitCnt=7; decode registered, outputs visible on the next cycle (latency 1 clk).
REQ-019 In CMD, completed frame: 2->cmdReady, 3->cmdStart, 4->cmdFull, 7->go to DATA (no pulse), any other value->frameErr; stay in CMD otherwise.
REQ-020 In DATA, completed frame: load rxData, set rxValid, return to CMD.
REQ-021 rxAck=1 while rxValid=1 clears rxValid next cycle; rxAck with rxValid=0 ignored.
REQ-022 Byte completes while rxValid=1 and rxAck=0: rxData overwritten, rxValid stays 1, rxOverflow set until reset.
REQ-023 Byte completes in same cycle as rxAck: new byte loaded, rxValid stays 1, no overflow.
REQ-024 Gap counter counts consecutive serClk=0 cycles while bitCnt!=0 or state=DATA; cleared by serClk=1.
REQ-025 Gap counter reaching TIMEOUT: frameErr pulse, bitCnt=0, shift register cleared, state CMD; counter saturates-free (reset to 0).
REQ-026 Never more than one of cmdReady/cmdStart/cmdFull/frameErr high in a cycle; timeout has priority if coincident.
REQ-027 readyForTransferOut is combinational from registered state only.

Reset
REQ-028 rst=0 asynchronously forces: ps=CMD, bitCnt=0, shift register=0, gap counter=0, rxData=0, rxValid=0, rxOverflow=0, all pulses 0.
REQ-029 Reset mid-frame discards partial bits; first serClk=1 after release is bit 0.

Structure
REQ-030 Shared package holds state encodings (CMD, DATA) and command codes (CMD_READY=2, CMD_START=3, CMD_FULL=4, CMD_DATA=7), shared with the scanner transmitter.
REQ-031 One sub-module natural: serial_shifter (8-bit shift register + bitCnt + frame-done strobe); FSM, decode and holding register in the top.

Verification
REQ-032 Send 0x02, 0x03, 0x04 back-to-back -> exactly one cmdReady, cmdStart, cmdFull pulse each, one cycle after each bit 7.
REQ-033 Send 0x07 then 0x05 -> ps CMD->DATA->CMD, rxData=0x05, rxValid=1, readyForTransferOut=0 until rxAck.
REQ-034 Send 0x09 -> frameErr pulse, no command pulse, state stays CMD.
REQ-035 Send 3 bits then hold serClk=0 for 16 cycles -> frameErr on cycle 16, next frame 0x02 decodes correctly.
REQ-036 Two data frames (0x07,0x0A then 0x07,0x0B) without rxAck -> rxData=0x0B, rxOverflow=1; repeat with rxAck coincident with second completion -> rxOverflow=0.
REQ-037 Assert rst=0 mid-frame asynchronously -> all outputs to reset values immediately; subsequent 0x04 gives cmdFull.
